// File: rtl/mulu_pkg.sv
// Shared definitions for the sequential shift-add multiplier (mulu_seq, mulu_1iter).
package mulu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PLEN  = 64;
    localparam int unsigned CNT_W = 6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulu_state_e;

endpackage

// File: rtl/mulu_1iter.sv
// One shift-add multiply step: conditionally add the multiplicand into the high
// half, then shift the {carry, hi, lo} accumulator right by one bit.
module mulu_1iter
    import mulu_pkg::*;
(
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] multiplicand,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;

    always_comb begin
        sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, multiplicand} : '0);
        hi_out = sum[XLEN:1];
        lo_out = {sum[0], lo_in[XLEN-1:1]};
    end

endmodule

// File: rtl/mulu_seq.sv
// Sequential 32x32 unsigned multiplier, one multiplier bit per cycle.
// Optional early exit when remaining multiplier bits are zero: MULU_SEQ_EARLY_EXIT_EN.
module mulu_seq
    import mulu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PLEN-1:0] product,
    output logic            busy
);

    mulu_state_e      state_q;
    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN-1:0]  hi_step;
    logic [XLEN-1:0]  lo_step;
    logic [PLEN-1:0]  acc_nxt;
    logic             run_last;

    mulu_1iter u_iter (
        .hi_in        (hi_q),
        .lo_in        (lo_q),
        .multiplicand (mcand_q),
        .hi_out       (hi_step),
        .lo_out       (lo_step)
    );

`ifdef MULU_SEQ_EARLY_EXIT_EN
    logic [XLEN-1:0]  rem_mask;
    logic [CNT_W-1:0] shamt;
    logic             rem_zero;

    // Once the unconsumed multiplier bits are all zero, every remaining step is
    // a plain right shift, so collapse them into one shift by (32 - cnt).
    always_comb begin
        rem_mask = {XLEN{1'b1}} >> cnt_q;
        rem_zero = ((lo_q & rem_mask) == '0);
        shamt    = CNT_W'(XLEN) - cnt_q;
        acc_nxt  = rem_zero ? ({hi_q, lo_q} >> shamt) : {hi_step, lo_step};
        run_last = rem_zero || (cnt_q == CNT_LAST);
    end
`else
    always_comb begin
        acc_nxt  = {hi_step, lo_step};
        run_last = (cnt_q == CNT_LAST);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= multiplicand;
                        hi_q    <= '0;
                        lo_q    <= multiplier;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    {hi_q, lo_q} <= acc_nxt;
                    cnt_q        <= cnt_q + 1'b1;
                    if (run_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        product   = {hi_q, lo_q};
    end

endmodule

// File: tb/tb_mulu_seq.sv
// Self-checking bench for mulu_seq (and mulu_1iter standalone) against an
// arithmetic reference model; honours MULU_SEQ_EARLY_EXIT_EN for latency.
module tb_mulu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;
    logic        busy;

    logic [31:0] it_hi = '0;
    logic [31:0] it_lo = '0;
    logic [31:0] it_m = '0;
    logic [31:0] it_hi_out;
    logic [31:0] it_lo_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mulu_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    mulu_1iter u_iter (
        .hi_in        (it_hi),
        .lo_in        (it_lo),
        .multiplicand (it_m),
        .hi_out       (it_hi_out),
        .lo_out       (it_lo_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] b);
`ifdef MULU_SEQ_EARLY_EXIT_EN
        int m;
        if (b == 0) return 1;
        m = 0;
        for (int i = 0; i < 32; i++) if (b[i]) m = i;
        return (m + 2 < 32) ? m + 2 : 32;
`else
        return 32;
`endif
    endfunction

    // Issue one request, measure latency, optionally stall the response for
    // 'hold' cycles, then complete the handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] exp_p;
        int          lat;
        exp_p = 64'(a) * 64'(b);
        @(posedge clk); #1;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        out_ready    = (hold == 0);
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk); #1;
        in_valid     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat > 0) check("busy_run", 64'(busy), 64'd1);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_latency(b)));
        check("product", product, exp_p);
        check("in_ready_done", 64'(in_ready), 64'd0);
        check("busy_done", 64'(busy), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_product", product, exp_p);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
        check("busy_drop", 64'(busy), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        // Standalone iteration step.
        it_hi = 32'hFFFF_FFFF; it_lo = 32'd1; it_m = 32'd1;
        #1;
        check("iter_hi_add", 64'(it_hi_out), 64'h8000_0000);
        check("iter_lo_add", 64'(it_lo_out), 64'h0);
        it_lo = 32'd0;
        #1;
        check("iter_hi_noadd", 64'(it_hi_out), 64'h7FFF_FFFF);
        check("iter_lo_noadd", 64'(it_lo_out), 64'h8000_0000);

        // Reset state.
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", product, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        run_op(32'd7, 32'd6, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
        run_op(32'h1234_5678, 32'd100, 0);
        run_op(32'hDEAD_BEEF, 32'd0, 1);
        run_op(32'd3, 32'h8000_0000, 2);
        run_op(32'd0, 32'hFFFF_FFFF, 0);

        // Mid-RUN reset abort.
        @(posedge clk); #1;
        in_valid = 1'b1; multiplicand = 32'd5; multiplier = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_product", product, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(32'd5, 32'd9, 0);

        // Randomized operands; shift the multiplier to vary its top set bit.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run_op(a, b, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
